// File: rtl/domain_xfer_arbiter.sv
// domain_xfer_arbiter: round-robin arbiter and sequencer sharing one Montgomery
// domain-transfer unit between the point-load and result-unload requesters.
module domain_xfer_arbiter #(
   parameter int WD_LIMIT = 40
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        mode0,
   input  logic        mode1,
   input  logic [31:0] x0,
   input  logic [31:0] y0,
   input  logic [31:0] x1,
   input  logic [31:0] y1,
   input  logic [31:0] prime,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rsp_x,
   output logic [31:0] rsp_y,
   output logic        rsp_err,
   output logic        busy,
   output logic        xfer_start,
   output logic        xfer_tomont,
   output logic [31:0] xfer_px,
   output logic [31:0] xfer_py,
   output logic [31:0] xfer_prime,
   input  logic [31:0] xfer_rx,
   input  logic [31:0] xfer_ry,
   input  logic        xfer_done
);
   localparam int WDW = $clog2(WD_LIMIT + 1) > 6 ? $clog2(WD_LIMIT + 1) : 6;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, GAP} state_t;
   state_t state_q, state_d;
   logic last_q, last_d, id_q, id_d, mode_q, mode_d, err_q, err_d, gnt_id;
   logic [31:0] px_q, px_d, py_q, py_d, prime_q, prime_d, rx_q, rx_d, ry_q, ry_d;
   logic [WDW-1:0] wd_q, wd_d;
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      mode_d  = mode_q;
      err_d   = err_q;
      px_d    = px_q;
      py_d    = py_q;
      prime_d = prime_q;
      rx_d    = rx_q;
      ry_d    = ry_q;
      wd_d    = wd_q;
      // on a tie the requester that was not served last wins
      gnt_id  = (req0 & req1) ? ~last_q : req1;
      case (state_q)
         IDLE: if (req0 | req1) begin
            id_d    = gnt_id;
            last_d  = gnt_id;
            mode_d  = gnt_id ? mode1 : mode0;
            px_d    = gnt_id ? x1 : x0;
            py_d    = gnt_id ? y1 : y0;
            prime_d = prime;
            if (!prime[0]) begin
               err_d   = 1'b1;
               rx_d    = '0;
               ry_d    = '0;
               state_d = ACK;
            end else state_d = ISSUE;
         end
         ISSUE: begin
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wd_d = (wd_q == WDW'(WD_LIMIT)) ? wd_q : wd_q + 1'b1;
            if (xfer_done) begin
               rx_d    = xfer_rx;
               ry_d    = xfer_ry;
               err_d   = 1'b0;
               state_d = ACK;
            end else if (wd_q >= WDW'(WD_LIMIT - 1)) begin
               rx_d    = '0;
               ry_d    = '0;
               err_d   = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         px_q    <= '0;
         py_q    <= '0;
         prime_q <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         px_q    <= px_d;
         py_q    <= py_d;
         prime_q <= prime_d;
         rx_q    <= rx_d;
         ry_q    <= ry_d;
         wd_q    <= wd_d;
      end
   end
   assign ack0        = (state_q == ACK) && !id_q;
   assign ack1        = (state_q == ACK) && id_q;
   assign rsp_x       = rx_q;
   assign rsp_y       = ry_q;
   assign rsp_err     = err_q;
   assign busy        = state_q != IDLE;
   assign xfer_start  = state_q == ISSUE;
   assign xfer_tomont = mode_q;
   assign xfer_px     = px_q;
   assign xfer_py     = py_q;
   assign xfer_prime  = prime_q;
endmodule

// File: tb/tb_domain_xfer_arbiter.sv
// tb_domain_xfer_arbiter: directed scenarios against a mod-23 transfer-unit model
// that answers 33 cycles after start (32 iterations plus one OUT cycle).
module tb_domain_xfer_arbiter;
   logic clk = 0, rst_n = 0, req0 = 0, req1 = 0, mode0 = 0, mode1 = 0;
   logic [31:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0, prime = 0;
   logic ack0, ack1, rsp_err, busy, xfer_start, xfer_tomont, xfer_done;
   logic [31:0] rsp_x, rsp_y, xfer_px, xfer_py, xfer_prime, xfer_rx, xfer_ry;
   logic model_en = 1, done_force = 0;
   logic [5:0] cnt;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   domain_xfer_arbiter #(.WD_LIMIT(40)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .prime(prime), .ack0(ack0), .ack1(ack1),
      .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy), .xfer_start(xfer_start),
      .xfer_tomont(xfer_tomont), .xfer_px(xfer_px), .xfer_py(xfer_py), .xfer_prime(xfer_prime),
      .xfer_rx(xfer_rx), .xfer_ry(xfer_ry), .xfer_done(xfer_done));

   // unit model for prime 23: 2^32 mod 23 = 12, 2^-32 mod 23 = 2
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= 0;
      else if (xfer_start) cnt <= 1;
      else if (cnt != 0 && cnt != 33) cnt <= cnt + 1;
      else cnt <= 0;
   assign xfer_done = (model_en && cnt == 33) || done_force;
   assign xfer_rx = (xfer_px * (xfer_tomont ? 32'd12 : 32'd2)) % 32'd23;
   assign xfer_ry = (xfer_py * (xfer_tomont ? 32'd12 : 32'd2)) % 32'd23;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(output int n, output int s, output int f);
      n = 0; s = 0; f = -1;
      do begin
         tick();
         n++;
         if (xfer_start) begin
            s++;
            if (f < 0) f = n;
         end
      end while (!(ack0 || ack1) && n < 100);
      checks++;
      if (n >= 100) begin errors++; $display("FAIL ack_timeout got no ack in %0d cycles want ack", n); end
   endtask

   task automatic test_reset();
      rst_n = 0;
      #1;
      checks++; if ({ack0, ack1, rsp_err, busy, xfer_start} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b want 00000", {ack0, ack1, rsp_err, busy, xfer_start}); end
      checks++; if ({rsp_x, rsp_y} !== 64'h0) begin errors++; $display("FAIL reset_rsp got %h want 0", {rsp_x, rsp_y}); end
      checks++; if ({xfer_px, xfer_py, xfer_prime, xfer_tomont} !== 97'h0) begin errors++; $display("FAIL reset_xfer got %h want 0", {xfer_px, xfer_py, xfer_prime}); end
      tick();
      rst_n = 1;
   endtask

   task automatic test_nominal();
      int n, s, f;
      prime = 23; req0 = 1; mode0 = 1; x0 = 5; y0 = 9;
      wait_ack(n, s, f);
      checks++; if (n !== 35) begin errors++; $display("FAIL nom_latency got %0d want 35", n); end
      checks++; if (s !== 1 || f !== 1) begin errors++; $display("FAIL nom_start got count %0d at %0d want 1 at 1", s, f); end
      checks++; if ({ack0, ack1} !== 2'b10) begin errors++; $display("FAIL nom_ack got %b want 10", {ack0, ack1}); end
      checks++; if (rsp_x !== 14 || rsp_y !== 16 || rsp_err !== 0) begin errors++; $display("FAIL nom_rsp got %0d %0d %b want 14 16 0", rsp_x, rsp_y, rsp_err); end
      checks++; if (xfer_px !== 5 || xfer_prime !== 23 || xfer_tomont !== 1) begin errors++; $display("FAIL nom_xfer got %0d %0d %b want 5 23 1", xfer_px, xfer_prime, xfer_tomont); end
      req0 = 0;
      tick();
      checks++; if (busy !== 1 || ack0 !== 0) begin errors++; $display("FAIL nom_gap got busy %b ack %b want 1 0", busy, ack0); end
      tick();
      checks++; if (busy !== 0) begin errors++; $display("FAIL nom_idle got busy %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int n, s, f;
      rst_n = 0;
      tick();
      rst_n = 1;
      mode0 = 0; mode1 = 0; x0 = 3; y0 = 4; x1 = 7; y1 = 10; prime = 23; req0 = 1; req1 = 1;
      for (int i = 0; i < 3; i++) begin
         wait_ack(n, s, f);
         checks++; if ({ack0, ack1} !== (i == 1 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL b2b_order%0d got %b", i, {ack0, ack1}); end
         checks++; if (f !== (i == 0 ? 1 : 3) || n !== (i == 0 ? 35 : 37)) begin errors++; $display("FAIL b2b_timing%0d got start %0d ack %0d", i, f, n); end
         checks++; if (rsp_x !== (i == 1 ? 14 : 6) || rsp_y !== (i == 1 ? 20 : 8)) begin errors++; $display("FAIL b2b_rsp%0d got %0d %0d", i, rsp_x, rsp_y); end
      end
      req0 = 0; req1 = 0;
      tick(); tick();
      checks++; if (busy !== 0) begin errors++; $display("FAIL b2b_idle got busy %b want 0", busy); end
   endtask

   task automatic test_watchdog();
      int n, s, f;
      model_en = 0; prime = 23; req0 = 1; mode0 = 1; x0 = 5; y0 = 9;
      wait_ack(n, s, f);
      checks++; if (n !== 42 || f !== 1) begin errors++; $display("FAIL wd_latency got ack %0d start %0d want 42 1", n, f); end
      checks++; if (ack0 !== 1 || rsp_err !== 1 || rsp_x !== 0 || rsp_y !== 0) begin errors++; $display("FAIL wd_rsp got ack %b err %b x %0d y %0d want 1 1 0 0", ack0, rsp_err, rsp_x, rsp_y); end
      req0 = 0; model_en = 1;
      tick(); tick();
      req1 = 1; mode1 = 0; x1 = 7; y1 = 10;
      wait_ack(n, s, f);
      checks++; if (n !== 35 || ack1 !== 1 || rsp_err !== 0 || rsp_x !== 14 || rsp_y !== 20) begin errors++; $display("FAIL wd_next got n %0d ack %b err %b x %0d y %0d want 35 1 0 14 20", n, ack1, rsp_err, rsp_x, rsp_y); end
      req1 = 0;
      tick(); tick();
   endtask

   task automatic test_bad_prime();
      int n, s, f;
      prime = 22; req1 = 1; mode1 = 1; x1 = 5; y1 = 9;
      wait_ack(n, s, f);
      checks++; if (n !== 1 || s !== 0) begin errors++; $display("FAIL bad_latency got ack %0d starts %0d want 1 0", n, s); end
      checks++; if (ack1 !== 1 || rsp_err !== 1 || rsp_x !== 0 || rsp_y !== 0) begin errors++; $display("FAIL bad_rsp got ack %b err %b x %0d y %0d want 1 1 0 0", ack1, rsp_err, rsp_x, rsp_y); end
      req1 = 0;
      tick();
      checks++; if (xfer_start !== 0) begin errors++; $display("FAIL bad_start got %b want 0", xfer_start); end
      tick();
   endtask

   task automatic test_stale_done();
      int n, s, f;
      done_force = 1;
      tick();
      checks++; if (busy !== 0 || ack0 !== 0 || ack1 !== 0) begin errors++; $display("FAIL stale_idle got busy %b acks %b%b want 0 00", busy, ack0, ack1); end
      done_force = 0;
      prime = 22; req0 = 1;
      wait_ack(n, s, f);
      req0 = 0; done_force = 1;
      tick();
      checks++; if (busy !== 1 || ack0 !== 0 || ack1 !== 0) begin errors++; $display("FAIL stale_gap got busy %b acks %b%b want 1 00", busy, ack0, ack1); end
      tick();
      checks++; if (busy !== 0 || ack0 !== 0 || ack1 !== 0 || xfer_start !== 0) begin errors++; $display("FAIL stale_after got busy %b acks %b%b want 0 00", busy, ack0, ack1); end
      done_force = 0;
   endtask

   task automatic test_reset_mid();
      int n, s, f;
      prime = 23; req0 = 1; mode0 = 1; x0 = 5; y0 = 9;
      repeat (10) tick();
      checks++; if (busy !== 1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
      rst_n = 0;
      #1;
      checks++; if ({busy, xfer_start, ack0, ack1, rsp_err} !== 5'b0 || {xfer_px, xfer_prime, rsp_x} !== 96'h0) begin errors++; $display("FAIL mid_reset got busy %b px %0d prime %0d", busy, xfer_px, xfer_prime); end
      tick();
      rst_n = 1;
      wait_ack(n, s, f);
      checks++; if (n !== 35 || ack0 !== 1 || rsp_x !== 14 || rsp_y !== 16 || rsp_err !== 0) begin errors++; $display("FAIL mid_regrant got n %0d ack %b x %0d y %0d err %b want 35 1 14 16 0", n, ack0, rsp_x, rsp_y, rsp_err); end
      req0 = 0;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_back_to_back();
      test_watchdog();
      test_bad_prime();
      test_stale_done();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/domain_xfer_arbiter.md
# domain_xfer_arbiter

Arbiter and sequencer that shares one 32-bit Montgomery domain-transfer unit between two requesters: the point-load path (requester 0) and the result-unload path (requester 1). It grants one request at a time using round-robin, latches the operands and prime, and pulses the unit's start. It captures the converted coordinates on the unit's done, guards the unit with a watchdog, and returns the result with a one-cycle acknowledge.

## Interface
- WD_LIMIT, 40: maximum cycles in WAIT before the watchdog aborts the operation.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0, req1  in  1  request; held high until the matching ack.
- mode0, mode1  in  1  1 = to Montgomery, 0 = to regular; stable while req is high.
- x0, y0, x1, y1  in  32  operand coordinates; stable while req is high.
- prime  in  32  modulus; sampled at grant.
- ack0, ack1  out  1  one-cycle response pulse.
- rsp_x, rsp_y  out  32  result; valid only while ack0 or ack1 is high.
- rsp_err  out  1  error flag; valid with ack.
- busy  out  1  high in every state except IDLE.
- xfer_start  out  1  start pulse to the unit (its in_sig).
- xfer_tomont  out  1  direction to the unit (its ToMont).
- xfer_px, xfer_py, xfer_prime  out  32  operands and modulus to the unit.
- xfer_rx, xfer_ry  in  32  unit result (Px_out, Py_out).
- xfer_done  in  1  unit done; result valid in that same cycle.

## Operation
- States: IDLE, ISSUE, WAIT, ACK, GAP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester other than the last granted one (`last`).
  - `last` resets to 1, so requester 0 wins the first tie.
  - At grant, latch the id, mode, x, y and prime, and update `last`.
  - If the latched prime is even or zero, go straight to ACK with rsp_err=1 and zero results. The unit is not started.
  - Otherwise go to ISSUE.
- ISSUE: xfer_start=1 for exactly one cycle, then WAIT. Clear the watchdog counter.
- WAIT:
  - Increment the watchdog counter each cycle.
  - On xfer_done=1, capture xfer_rx/xfer_ry into the result registers, set err=0, go to ACK.
  - If the counter reaches WD_LIMIT without done, set err=1, zero the results, go to ACK.
- ACK: assert the ack of the granted id for one cycle, with rsp_x, rsp_y and rsp_err driven from the registers. Then go to GAP.
- GAP: one cycle in which requests are ignored, so a requester can drop req after seeing ack. Then go to IDLE.
- xfer_px, xfer_py, xfer_tomont and xfer_prime are driven from the latched registers. They stay stable from ISSUE through ACK.
- xfer_done is ignored in every state except WAIT. This covers an unreset or stale done from the unit.
- No request is ever dropped. A losing requester keeps req high and is granted at the next IDLE.

## Timing
- Reset values:
  - State IDLE, `last`=1.
  - ack0, ack1, rsp_err, busy and xfer_start are 0.
  - rsp_x, rsp_y and all xfer_* data outputs are 0.
  - Watchdog counter is 0.
- All outputs are registered or decoded from the state; there are no combinational input-to-output paths.
- Nominal latency, with the unit taking 32 iterations plus one OUT cycle:
  - req sampled in IDLE at cycle 0, ISSUE in cycle 1, done at cycle 34, ack at cycle 35.
  - The unit must see at least one idle cycle before the next start. GAP plus IDLE provide it.
- Invalid-prime latency: ack in cycle 1 after the grant.
- Back-to-back requests: next grant at the earliest 2 cycles after an ack (GAP, then IDLE).
- Reset asserted mid-operation:
  - Immediately return to the reset state.
  - Any pending ack is lost, and xfer_start is forced to 0.
  - The requester must re-request.
- The watchdog counter is at least 6 bits and saturates at WD_LIMIT.

## Test plan
- Reset, then req0=1, mode0=1, x0=5, y0=9, prime=23, with a unit model returning 2^32·v mod 23 at done cycle 34 → ack0 at cycle 35 with rsp_x=(5·2^32) mod 23, rsp_err=0, and xfer_start high only in cycle 1.
- req0 and req1 held high together from reset → grants go 0, 1, 0 in order; each ack is followed by at least 2 cycles before the next ISSUE.
- req1=1 with prime=22 → ack1 one cycle after the grant, rsp_err=1, rsp_x=rsp_y=0, and xfer_start never asserted.
- Unit model that never raises done → ack with rsp_err=1 exactly WAIT + WD_LIMIT cycles after ISSUE; the arbiter then returns to IDLE and accepts the next request.
- xfer_done pulsed while in IDLE and GAP → no ack, no state change.
- reset pulled low during WAIT → all outputs 0 at once; after release with req0 still high, the request is re-granted and completes normally.
